// File: rtl/vam_seq_multiplier.sv
// Iterative shift-add multiplier, unsigned or two's-complement per operation.
// One partial product per cycle; fixed latency of WIDTH CALC cycles plus one DONE cycle.
module vam_seq_multiplier #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signedMode,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  output logic [2*WIDTH-1:0] outW,
  output logic               readyPulse,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q, mplr_q;
  logic [2*WIDTH-1:0] acc_q, out_q;
  logic               neg_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] addend, acc_sum;
  logic               last_iter;

  // Magnitudes kept in WIDTH unsigned bits so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    mag_a     = (signedMode && inA[WIDTH-1]) ? -inA : inA;
    mag_b     = (signedMode && inB[WIDTH-1]) ? -inB : inB;
    addend    = mplr_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    acc_sum   = acc_q + addend;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q <= mag_a;
            mplr_q  <= mag_b;
            neg_q   <= signedMode & (inA[WIDTH-1] ^ inB[WIDTH-1]);
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StCalc: begin
          acc_q  <= acc_sum;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            out_q <= neg_q ? -acc_sum : acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    outW       = out_q;
    readyPulse = (state_q == StDone);
    busy       = (state_q != StIdle);
  end

endmodule
